// File: rtl/alu_mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier that drives the external ripple ALU.
// Defining ALU_MULT_SIGNED_EN selects two's-complement operands and product.
package alu_mult_pkg;

    localparam int ALU_MULT_WIDTH = 32;
    localparam int MULT_STEPS     = ALU_MULT_WIDTH;

    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_OR  = 3'b001;
    localparam logic [2:0] ALU_OP_ADD = 3'b010;
    localparam logic [2:0] ALU_OP_SUB = 3'b110;
    localparam logic [2:0] ALU_OP_SLT = 3'b111;

`ifdef ALU_MULT_SIGNED_EN
    localparam bit MULT_SIGNED = 1'b1;
`else
    localparam bit MULT_SIGNED = 1'b0;
`endif

    typedef enum logic [1:0] {
        MULT_IDLE = 2'd0,
        MULT_RUN  = 2'd1,
        MULT_DONE = 2'd2
    } alu_mult_state_t;

endpackage

// File: rtl/alu_mult_step.sv
// One multiply step: chooses the ALU addend and carry-in, then forms the shifted partial product.
// With ALU_MULT_SIGNED_EN the final step subtracts M and the shifted-in bit is the true sum sign.
module alu_mult_step
    import alu_mult_pkg::*;
#(
    parameter int WIDTH = ALU_MULT_WIDTH
) (
    input  logic             i_run,
    input  logic             i_last,
    input  logic [WIDTH-1:0] i_m,
    input  logic [WIDTH-1:0] i_p_hi,
    input  logic [WIDTH-1:0] i_p_lo,
    input  logic [WIDTH-1:0] i_alu_r,
    input  logic             i_alu_cout,
    output logic [WIDTH-1:0] o_alu_b,
    output logic             o_alu_cin,
    output logic             o_top,
    output logic [WIDTH-1:0] o_p_hi_next,
    output logic [WIDTH-1:0] o_p_lo_next
);

    logic w_add;
    logic w_sub;
    logic w_true_sign;

    assign w_add = i_run & i_p_lo[0];
    // The multiplier's sign bit carries negative weight, so its partial product is subtracted.
    assign w_sub = w_add & i_last & MULT_SIGNED;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
        assign o_alu_b[gi] = w_add & (i_m[gi] ^ w_sub);
    end

    assign o_alu_cin   = w_sub;
    assign w_true_sign = i_p_hi[WIDTH-1] ^ o_alu_b[WIDTH-1] ^ i_alu_cout;
    assign o_top       = MULT_SIGNED ? w_true_sign : i_alu_cout;

    assign o_p_hi_next = {o_top, i_alu_r[WIDTH-1:1]};
    assign o_p_lo_next = {i_alu_r[0], i_p_lo[WIDTH-1:1]};

endmodule

// File: rtl/alu_mult_seq.sv
// Sequential 32x32 shift-and-add multiplier; one external ALU addition per cycle, valid/ready on both sides.
// Defining ALU_MULT_SIGNED_EN makes operands and product two's complement.
module alu_mult_seq
    import alu_mult_pkg::*;
#(
    parameter int WIDTH = ALU_MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic               alu_cin,
    output logic               alu_cless_than,
    output logic [2:0]         alu_op,
    input  logic [WIDTH-1:0]   alu_r,
    input  logic               alu_cout
);

    localparam int CNT_W = $clog2(WIDTH);

    alu_mult_state_t    r_state;
    alu_mult_state_t    w_state_next;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_p_hi;
    logic [WIDTH-1:0]   r_p_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_product;

    logic               w_run;
    logic               w_last;
    logic               w_top;
    logic [WIDTH-1:0]   w_p_hi_next;
    logic [WIDTH-1:0]   w_p_lo_next;

    assign w_run  = (r_state == MULT_RUN);
    assign w_last = (r_cnt == CNT_W'(MULT_STEPS - 1));

    alu_mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_run       (w_run),
        .i_last      (w_last),
        .i_m         (r_m),
        .i_p_hi      (r_p_hi),
        .i_p_lo      (r_p_lo),
        .i_alu_r     (alu_r),
        .i_alu_cout  (alu_cout),
        .o_alu_b     (alu_b),
        .o_alu_cin   (alu_cin),
        .o_top       (w_top),
        .o_p_hi_next (w_p_hi_next),
        .o_p_lo_next (w_p_lo_next)
    );

    // The ALU is shared later, so it sees zeros whenever no step is in progress.
    assign alu_a          = w_run ? r_p_hi : '0;
    assign alu_op         = ALU_OP_ADD;
    assign alu_cless_than = 1'b0;
    assign start_ready    = (r_state == MULT_IDLE);
    assign res_valid      = (r_state == MULT_DONE);
    assign product        = r_product;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MULT_IDLE: if (start_valid) w_state_next = MULT_RUN;
            MULT_RUN:  if (w_last)      w_state_next = MULT_DONE;
            MULT_DONE: if (res_ready)   w_state_next = MULT_IDLE;
            default:                    w_state_next = MULT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= MULT_IDLE;
            r_m       <= '0;
            r_p_hi    <= '0;
            r_p_lo    <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                MULT_IDLE: begin
                    if (start_valid) begin
                        r_m    <= multiplicand;
                        r_p_hi <= '0;
                        r_p_lo <= multiplier;
                        r_cnt  <= '0;
                    end
                end
                MULT_RUN: begin
                    r_p_hi <= w_p_hi_next;
                    r_p_lo <= w_p_lo_next;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_product <= {w_p_hi_next, w_p_lo_next};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Self-checking bench for alu_mult_seq with a behavioural ALU and a queue-based product model.
// Expectations follow ALU_MULT_SIGNED_EN when it is defined.
module tb_alu_mult_seq;

    localparam int W        = 32;
    localparam int MULT_LAT = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_valid = 1'b0;
    logic           start_ready;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [2*W-1:0] product;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic           alu_cin;
    logic           alu_cless_than;
    logic [2:0]     alu_op;
    logic [W-1:0]   alu_r;
    logic           alu_cout;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;

    logic [2*W-1:0] exp_q[$];
    int             acc_q[$];
    int             acc_hist[$];

    always #5 clk = ~clk;

    alu_mult_seq #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_valid    (start_valid),
        .start_ready    (start_ready),
        .multiplicand   (multiplicand),
        .multiplier     (multiplier),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .product        (product),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_cin        (alu_cin),
        .alu_cless_than (alu_cless_than),
        .alu_op         (alu_op),
        .alu_r          (alu_r),
        .alu_cout       (alu_cout)
    );

    // Stand-in for the combinational ripple ALU.
    always_comb begin
        {alu_cout, alu_r} = '0;
        case (alu_op)
            3'b000:  alu_r = alu_a & alu_b;
            3'b001:  alu_r = alu_a | alu_b;
            3'b010:  {alu_cout, alu_r} = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
            default: {alu_cout, alu_r} = '0;
        endcase
    end

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
`ifdef ALU_MULT_SIGNED_EN
        logic signed [2*W-1:0] sm;
        logic signed [2*W-1:0] sq;
        sm = $signed(m);
        sq = $signed(q);
        return sm * sq;
`else
        return {{W{1'b0}}, m} * {{W{1'b0}}, q};
`endif
    endfunction

    task automatic check64(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // Model: one operation in flight; accepted when idle, result valid MULT_LAT edges later, retired on res_ready.
    task automatic model_edge();
        int  next_edge;
        bit  idle;
        next_edge = edge_cnt + 1;
        idle = (exp_q.size() == 0);
        if (!idle && (edge_cnt - acc_q[0] >= MULT_LAT) && res_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
        end
        if (idle && start_valid) begin
            exp_q.push_back(ref_mul(multiplicand, multiplier));
            acc_q.push_back(next_edge);
            acc_hist.push_back(next_edge);
            $display("accept edge=%0d m=%h q=%h exp=%h", next_edge, multiplicand, multiplier,
                     ref_mul(multiplicand, multiplier));
        end
        edge_cnt = next_edge;
    endtask

    task automatic model_reset();
        exp_q.delete();
        acc_q.delete();
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_edge();
    end

    task automatic compare_cycle();
        bit busy;
        bit exp_valid;
        bit running;
        int diff;
        busy      = (exp_q.size() != 0);
        diff      = busy ? (edge_cnt - acc_q[0]) : 0;
        exp_valid = busy && (diff >= MULT_LAT);
        running   = busy && (diff < MULT_LAT);
        check64("start_ready", {63'd0, start_ready}, {63'd0, !busy});
        check64("res_valid", {63'd0, res_valid}, {63'd0, exp_valid});
        if (exp_valid) check64("product", product, exp_q[0]);
        if (!running) begin
            check64("alu_ab_idle", {alu_a, alu_b}, '0);
            check64("alu_cin_idle", {63'd0, alu_cin}, '0);
        end
        check64("alu_op", {61'd0, alu_op}, 64'd2);
        check64("alu_cless_than", {63'd0, alu_cless_than}, '0);
    endtask

    always @(negedge clk) begin
        if (rst_n) compare_cycle();
    end

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
    endtask

    task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q,
                         input logic [2*W-1:0] lit, input string name);
        int lat;
        @(negedge clk); #1;
        multiplicand = m;
        multiplier   = q;
        start_valid  = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_int({name, "_latency"}, lat, MULT_LAT);
        check64(name, product, lit);
        $display("op %s m=%h q=%h product=%h latency=%0d", name, m, q, product, lat);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check64({name, "_idle_after"}, {63'd0, start_ready}, 64'd1);
    endtask

    initial begin
        logic [2*W-1:0] held;
        int             n;

        #12;
        check64("rst_start_ready", {63'd0, start_ready}, 64'd1);
        check64("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check64("rst_product", product, 64'd0);
        check64("rst_alu_ab", {alu_a, alu_b}, 64'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Hand-computed literal products.
        do_op(32'd7, 32'd6, 64'h0000_0000_0000_002A, "u7x6");
        do_op(32'd0, 32'h1234_5678, 64'd0, "zero");
`ifdef ALU_MULT_SIGNED_EN
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "m1xm1");
        do_op(32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, "s_m3x5");
        do_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "s_minxmin");
        do_op(32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, "s_minx1");
        do_op(32'd5, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFF1, "s_5xm3");
`else
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "umaxsq");
        do_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "u_msbsq");
        do_op(32'h8000_0000, 32'd3, 64'h0000_0001_8000_0000, "u_msbx3");
`endif

        // Backpressure: product held, start pulse ignored.
        @(negedge clk); #1;
        multiplicand = $urandom;
        multiplier   = $urandom;
        start_valid  = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        held = product;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            start_valid = (i == 5);
            multiplicand = $urandom;
        end
        @(negedge clk); #1;
        start_valid = 1'b0;
        check64("bp_product_held", product, held);
        check64("bp_res_valid_held", {63'd0, res_valid}, 64'd1);
        check64("bp_start_ready_low", {63'd0, start_ready}, 64'd0);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check64("bp_release_idle", {63'd0, start_ready}, 64'd1);
        check64("bp_release_valid", {63'd0, res_valid}, 64'd0);

        // Reset in the middle of a run, after the step with cnt 14 has landed.
        @(negedge clk); #1;
        multiplicand = 32'hDEAD_BEEF;
        multiplier   = 32'h1357_9BDF;
        start_valid  = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check64("midrst_start_ready", {63'd0, start_ready}, 64'd1);
        check64("midrst_res_valid", {63'd0, res_valid}, 64'd0);
        check64("midrst_product", product, 64'd0);
        check64("midrst_alu_ab", {alu_a, alu_b}, 64'd0);
        check64("midrst_alu_cin", {63'd0, alu_cin}, 64'd0);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        do_op(32'd9, 32'd9, 64'd81, "post_rst_9x9");

        // Back-to-back with start_valid held high.
        acc_hist.delete();
        @(negedge clk); #1;
        start_valid = 1'b1;
        res_ready   = 1'b1;
        for (int i = 0; i < 34 * 5; i++) begin
            multiplicand = $urandom;
            multiplier   = $urandom;
            @(negedge clk); #1;
        end
        start_valid = 1'b0;
        wait_idle(80);
        check_int("b2b_accept_count_ge2", (acc_hist.size() >= 2) ? 1 : 0, 1);
        for (int i = 1; i < acc_hist.size(); i++) begin
            check_int("b2b_spacing", acc_hist[i] - acc_hist[i-1], 34);
        end

        // Random traffic with random backpressure and corner operands.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk); #1;
            start_valid = ($urandom_range(0, 3) == 0);
            res_ready   = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 5))
                0:       multiplicand = 32'h8000_0000;
                1:       multiplicand = 32'hFFFF_FFFF;
                default: multiplicand = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       multiplier = 32'h8000_0000;
                1:       multiplier = 32'hFFFF_FFFF;
                2:       multiplier = 32'd1;
                default: multiplier = $urandom;
            endcase
        end
        start_valid = 1'b0;
        res_ready   = 1'b1;
        wait_idle(80);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
